// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL reset sequencer.
// Holds the state encoding and the status-counter saturation limit.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  localparam logic [3:0] CNT_SAT = 4'hF;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == CNT_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: generic two-flop synchronizer for asynchronous status lines.
// Both stages clear on a synchronous active-high reset.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: drives the PLL reset, qualifies lock, then releases
// the system reset of the PLL-clocked domain; retries on timeout/loss.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned RELEASE_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       lock_i,
  input  logic       force_relock_i,
  output logic       pll_rstn_o,
  output logic       sys_reset_o,
  output logic       ready_o,
  output logic [3:0] retry_cnt_o,
  output logic [3:0] loss_cnt_o,
  output logic [2:0] state_o
);

  localparam int unsigned M0 =
    (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned M1 =
    (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
  localparam int unsigned MAXP = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(MAXP);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);

  logic       lock_s;
  pll_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d;
  logic [3:0] loss_q, loss_d;
  logic       pll_rstn_q;
  logic       sys_reset_q;
  logic       ready_q;

  sync2 #(
    .W(1)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (lock_i),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    // A relock request outranks any timeout or loss seen this cycle.
    if (force_relock_i && (state_q != PLL_RST)) begin
      state_d = PLL_RST;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TO_LAST) begin
            retry_d = sat_inc(retry_q);
            state_d = PLL_RST;
          end
        end
        STABLE: begin
          if (!lock_s) state_d = WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = RELEASE;
        end
        RELEASE: begin
          if (!lock_s) begin
            loss_d  = sat_inc(loss_q);
            state_d = PLL_RST;
          end else if (cnt_q == REL_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!lock_s) begin
            loss_d  = sat_inc(loss_q);
            state_d = PLL_RST;
          end
        end
        default: state_d = PLL_RST;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rstn_q  <= 1'b0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rstn_q  <= (state_q != PLL_RST);
      sys_reset_q <= (state_q != RUN);
      ready_q     <= (state_q == RUN);
    end
  end

  assign pll_rstn_o  = pll_rstn_q;
  assign sys_reset_o = sys_reset_q;
  assign ready_o     = ready_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: scenario bench for pll_reset_seq; expected timing
// is derived from the sequencing rules with plain edge arithmetic.
module tb_pll_reset_seq;

  localparam int RST_N = 4;
  localparam int TO    = 32;
  localparam int STB   = 8;
  localparam int REL   = 4;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       lock_i = 1'b0;
  logic       force_relock_i = 1'b0;
  logic       pll_rstn_o;
  logic       sys_reset_o;
  logic       ready_o;
  logic [3:0] retry_cnt_o;
  logic [3:0] loss_cnt_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pll_reset_seq #(
    .PLL_RST_CYCLES(RST_N),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (STB),
    .RELEASE_CYCLES(REL)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .lock_i        (lock_i),
    .force_relock_i(force_relock_i),
    .pll_rstn_o    (pll_rstn_o),
    .sys_reset_o   (sys_reset_o),
    .ready_o       (ready_o),
    .retry_cnt_o   (retry_cnt_o),
    .loss_cnt_o    (loss_cnt_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Edge 0 is the last edge sampling reset_i=1.
  task automatic do_reset();
    reset_i = 1'b1;
    lock_i = 1'b0;
    force_relock_i = 1'b0;
    tick();
    cyc = 0;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] want;
    logic [13:0] got;
    reset_i = 1'b1;
    lock_i = 1'($urandom_range(0, 1));
    force_relock_i = 1'($urandom_range(0, 1));
    tick();
    want = {1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'd0};
    got = {pll_rstn_o, sys_reset_o, ready_o,
           retry_cnt_o, loss_cnt_o, state_o};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", got, want);
    end
  endtask

  task automatic test_clean_lock();
    int lset[3];
    lset[0] = $urandom_range(5, 30);
    lset[1] = RST_N + TO - 2;
    lset[2] = RST_N + TO - 1;
    foreach (lset[k]) begin
      int l;
      int timed;
      int fall;
      logic [2:0] want;
      l = lset[k];
      timed = (l + 2 > RST_N + TO) ? 1 : 0;
      fall = (timed != 0) ? (2 * RST_N + TO + 1 + STB + REL + 1)
                          : (l + 2 + STB + REL + 1);
      do_reset();
      while (cyc < fall + 5) begin
        if (cyc == l - 1) lock_i = 1'b1;
        tick();
        want = {(cyc >= RST_N + 1) &&
                !((timed != 0) && cyc > RST_N + TO &&
                  cyc <= 2 * RST_N + TO),
                cyc < fall, cyc >= fall};
        checks++;
        if ({pll_rstn_o, sys_reset_o, ready_o} !== want) begin
          errors++;
          $display("FAIL clean_lock L=%0d edge %0d: got %b want %b",
                   l, cyc, {pll_rstn_o, sys_reset_o, ready_o}, want);
        end
      end
      checks++;
      if (retry_cnt_o !== 4'(timed) || loss_cnt_o !== 4'd0 ||
          state_o !== 3'd4) begin
        errors++;
        $display("FAIL clean_lock_status L=%0d: got r%0d l%0d s%0d want r%0d l0 s4",
                 l, retry_cnt_o, loss_cnt_o, state_o, timed);
      end
    end
  endtask

  task automatic test_timeout();
    int per;
    int j;
    int m;
    logic want;
    per = RST_N + TO;
    do_reset();
    while (cyc < RST_N + 17 * per) begin
      tick();
      j = cyc - 1;
      want = (j >= RST_N) && (((j - RST_N) % per) < TO);
      checks++;
      if (pll_rstn_o !== want) begin
        errors++;
        $display("FAIL timeout_rstn edge %0d: got %b want %b",
                 cyc, pll_rstn_o, want);
      end
      if (cyc >= RST_N && ((cyc - RST_N) % per) == TO / 2) begin
        m = (cyc - RST_N) / per;
        if (m > 15) m = 15;
        checks++;
        if (retry_cnt_o !== 4'(m)) begin
          errors++;
          $display("FAIL timeout_retry edge %0d: got %0d want %0d",
                   cyc, retry_cnt_o, m);
        end
      end
    end
  endtask

  task automatic test_unstable();
    int ph;
    int bad;
    ph = $urandom_range(0, 5);
    bad = 0;
    do_reset();
    while (cyc < 300) begin
      lock_i = ((cyc + ph) % 6) != 5;
      tick();
      if (cyc < RST_N) begin
        if (state_o !== 3'd0) bad++;
      end else if (state_o !== 3'd1 && state_o !== 3'd2) begin
        bad++;
      end
      if (sys_reset_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL unstable_states: got %0d bad edges want 0", bad);
    end
    checks++;
    if (retry_cnt_o !== 4'd0 || loss_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL unstable_counts: got r%0d l%0d want r0 l0",
               retry_cnt_o, loss_cnt_o);
    end
  endtask

  task automatic test_loss_run();
    int l;
    int t;
    int n;
    int d;
    int e;
    int want_loss;
    logic [2:0] want;
    l = $urandom_range(5, 12);
    t = l + 15 + $urandom_range(1, 10);
    n = $urandom_range(15, 17);
    do_reset();
    while (cyc < t) begin
      if (cyc == l - 1) lock_i = 1'b1;
      tick();
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL loss_pre_run: got ready %b want 1", ready_o);
    end
    for (int m = 1; m <= n; m++) begin
      d = cyc + 1;
      lock_i = 1'b0;
      while (cyc < d + 22) begin
        if (cyc == d + 2) lock_i = 1'b1;
        tick();
        e = cyc - d;
        want = {!(e >= 3 && e <= 6), (e >= 3 && e <= 19),
                !(e >= 3 && e <= 19)};
        checks++;
        if ({pll_rstn_o, sys_reset_o, ready_o} !== want) begin
          errors++;
          $display("FAIL loss_seq #%0d +%0d: got %b want %b",
                   m, e, {pll_rstn_o, sys_reset_o, ready_o}, want);
        end
      end
      want_loss = (m > 15) ? 15 : m;
      checks++;
      if (loss_cnt_o !== 4'(want_loss) || retry_cnt_o !== 4'd0) begin
        errors++;
        $display("FAIL loss_count #%0d: got l%0d r%0d want l%0d r0",
                 m, loss_cnt_o, retry_cnt_o, want_loss);
      end
    end
  endtask

  task automatic test_simultaneous();
    int l;
    int d;
    int f;
    int r;
    logic [13:0] want;
    logic [13:0] got;
    l = $urandom_range(5, 12);
    do_reset();
    while (cyc < l + 18) begin
      if (cyc == l - 1) lock_i = 1'b1;
      tick();
    end
    // Relock request lands on the edge the FSM sees the lock drop.
    d = cyc + 1;
    lock_i = 1'b0;
    tick();
    tick();
    force_relock_i = 1'b1;
    tick();
    force_relock_i = 1'b0;
    lock_i = 1'b1;
    tick();
    checks++;
    if (sys_reset_o !== 1'b1 || ready_o !== 1'b0 ||
        loss_cnt_o !== 4'd0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL force_vs_loss: got sr%b rdy%b l%0d s%0d want sr1 rdy0 l0 s0",
               sys_reset_o, ready_o, loss_cnt_o, state_o);
    end
    force_relock_i = 1'b1;
    tick();
    force_relock_i = 1'b0;
    while (cyc < d + 6) tick();
    checks++;
    if (pll_rstn_o !== 1'b0) begin
      errors++;
      $display("FAIL force_ignored_lo: got %b want 0", pll_rstn_o);
    end
    tick();
    checks++;
    if (pll_rstn_o !== 1'b1) begin
      errors++;
      $display("FAIL force_ignored_hi: got %b want 1", pll_rstn_o);
    end
    while (cyc < d + 19) tick();
    checks++;
    if (sys_reset_o !== 1'b1) begin
      errors++;
      $display("FAIL relock_hold: got %b want 1", sys_reset_o);
    end
    tick();
    checks++;
    if (sys_reset_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL relock_release: got sr%b rdy%b want sr0 rdy1",
               sys_reset_o, ready_o);
    end
    f = cyc + 1;
    force_relock_i = 1'b1;
    tick();
    force_relock_i = 1'b0;
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL force_run_state: got %0d want 0", state_o);
    end
    tick();
    checks++;
    if (pll_rstn_o !== 1'b0 || sys_reset_o !== 1'b1 ||
        loss_cnt_o !== 4'd0 || retry_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL force_run_out: got rn%b sr%b l%0d r%0d want rn0 sr1 l0 r0",
               pll_rstn_o, sys_reset_o, loss_cnt_o, retry_cnt_o);
    end
    r = f + $urandom_range(14, 17);
    while (cyc < r - 1) tick();
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_release: got state %0d want 3", state_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    want = {1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'd0};
    got = {pll_rstn_o, sys_reset_o, ready_o,
           retry_cnt_o, loss_cnt_o, state_o};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_in_release: got %b want %b", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_timeout();
    test_unstable();
    test_loss_run();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
